// File: rtl/jtkunio_obj_pkg.sv
// ============================================================================
// jtkunio_obj_pkg
// Shared constants for the object line buffer: geometry, command size,
// draw FSM encoding and the transparent pixel index.
// Revision: 1.0
// ============================================================================
`default_nettype none

package jtkunio_obj_pkg;
    localparam int AW         = 8;
    localparam int PW         = 6;
    localparam int CMD_PIXELS = 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_DRAW = 1'b1;

    localparam logic [2:0] TRANSP_IDX = 3'd0;
endpackage

`default_nettype wire

// File: rtl/jtkunio_obj_lbuf_ram.sv
// ============================================================================
// jtkunio_obj_lbuf_ram
// Two-bank dual-port pixel RAM. Both ports read synchronously, read-before-write.
// Revision: 1.0
// ============================================================================
`default_nettype none

module jtkunio_obj_lbuf_ram #(
    parameter int AW = 8,
    parameter int PW = 6
) (
    input  logic          clk,
    input  logic [AW:0]   i_a_addr,
    input  logic [PW-1:0] i_a_din,
    input  logic          i_a_we,
    output logic [PW-1:0] o_a_dout,
    input  logic [AW:0]   i_b_addr,
    input  logic [PW-1:0] i_b_din,
    input  logic          i_b_we,
    output logic [PW-1:0] o_b_dout
);
    logic [PW-1:0] r_mem [0:(2**(AW+1))-1];

    // Port A only touches the write bank and port B only the display bank,
    // so the two writes never target the same word.
    always_ff @(posedge clk) begin
        if (i_a_we) r_mem[i_a_addr] <= i_a_din;
        if (i_b_we) r_mem[i_b_addr] <= i_b_din;
        o_a_dout <= r_mem[i_a_addr];
        o_b_dout <= r_mem[i_b_addr];
    end
endmodule

`default_nettype wire

// File: rtl/jtkunio_obj_linebuf.sv
// ============================================================================
// jtkunio_obj_linebuf
// Double-buffered object line buffer: 8-pixel draw engine, bank swap at
// horizontal blank, read-and-erase readout. Option: JTKUNIO_OBJ_PRIO_EN
// (first-written object wins, 2 clk per pixel).
// Revision: 1.0
// ============================================================================
`default_nettype none

module jtkunio_obj_linebuf #(
    parameter int AW = jtkunio_obj_pkg::AW,
    parameter int PW = jtkunio_obj_pkg::PW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pxl_cen,
    input  logic          LHBL,
    input  logic [AW-1:0] hdump,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_x,
    input  logic [2:0]    cmd_pal,
    input  logic [23:0]   cmd_data,
    input  logic          cmd_hflip,
    output logic [PW-1:0] obj_pxl
);
    import jtkunio_obj_pkg::*;

`ifdef JTKUNIO_OBJ_PRIO_EN
    localparam int SW = 4;
`else
    localparam int SW = 3;
`endif

    logic          r_lhbl_d;
    logic          r_bank;
    logic          w_swap;
    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic [SW-1:0] r_step;
    logic [AW-1:0] r_x;
    logic [2:0]    r_pal;
    logic [23:0]   r_data;
    logic          r_hflip;
    logic          w_accept;
    logic          w_drawing;
    logic          w_last;
    logic [2:0]    w_n;
    logic [2:0]    w_ofs;
    logic [4:0]    w_sel;
    logic [2:0]    w_idx;
    logic [AW:0]   w_col;
    logic          w_a_we;
    logic [AW:0]   w_a_addr;
    logic [PW-1:0] w_a_din;
    logic [PW-1:0] w_a_dout;
    logic          w_unused_a;
    logic          w_b_we;
    logic [AW:0]   w_b_addr;
    logic [PW-1:0] w_b_dout;
    logic [AW:0]   r_rd_addr;
    logic          r_rd_pend;
    logic          r_erase;
    logic [PW-1:0] r_hold;
    logic [PW-1:0] r_obj_pxl;

    assign w_swap = r_lhbl_d & ~LHBL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lhbl_d <= 1'b0;
            r_bank   <= 1'b0;
        end else begin
            r_lhbl_d <= LHBL;
            if (w_swap) r_bank <= ~r_bank;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // A swap mid-draw abandons the rest of the command.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)         w_state_nxt = ST_DRAW;
            ST_DRAW: if (w_swap || w_last) w_state_nxt = ST_IDLE;
            default:                       w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == ST_IDLE);
    end

    assign w_accept  = cmd_valid & cmd_ready;
    assign w_drawing = (r_state == ST_DRAW);
    assign w_last    = &r_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step  <= '0;
            r_x     <= '0;
            r_pal   <= 3'd0;
            r_data  <= 24'd0;
            r_hflip <= 1'b0;
        end else if (w_accept) begin
            r_step  <= '0;
            r_x     <= cmd_x;
            r_pal   <= cmd_pal;
            r_data  <= cmd_data;
            r_hflip <= cmd_hflip;
        end else if (w_drawing) begin
            r_step  <= r_step + 1'b1;
        end
    end

`ifdef JTKUNIO_OBJ_PRIO_EN
    assign w_n = r_step[3:1];
`else
    assign w_n = r_step[2:0];
`endif
    assign w_ofs = r_hflip ? (3'd7 - w_n) : w_n;
    assign w_sel = {2'b00, w_n} * 5'd3;
    assign w_idx = r_data[w_sel +: 3];
    // The extra MSB is the carry: columns past the line end are dropped.
    assign w_col = {1'b0, r_x} + {{(AW-2){1'b0}}, w_ofs};

`ifdef JTKUNIO_OBJ_PRIO_EN
    // Odd step writes using the word fetched on the even step.
    assign w_a_we = w_drawing & ~w_swap & ~w_col[AW] & (w_idx != TRANSP_IDX)
                  & r_step[0] & (w_a_dout[2:0] == TRANSP_IDX);
    assign w_unused_a = ^w_a_dout[PW-1:3];
`else
    assign w_a_we = w_drawing & ~w_swap & ~w_col[AW] & (w_idx != TRANSP_IDX);
    assign w_unused_a = ^w_a_dout;
`endif
    assign w_a_addr = {r_bank, w_col[AW-1:0]};
    assign w_a_din  = {r_pal, w_idx};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr <= '0;
            r_rd_pend <= 1'b0;
            r_erase   <= 1'b0;
            r_hold    <= '0;
            r_obj_pxl <= '0;
        end else begin
            r_rd_pend <= pxl_cen;
            r_erase   <= r_rd_pend;
            if (pxl_cen)   r_rd_addr <= {~r_bank, hdump};
            if (r_rd_pend) r_hold    <= w_b_dout;
            if (pxl_cen)   r_obj_pxl <= LHBL ? r_hold : '0;
        end
    end

    assign w_b_we   = r_erase;
    assign w_b_addr = r_erase ? r_rd_addr : {~r_bank, hdump};
    assign obj_pxl  = r_obj_pxl;

    jtkunio_obj_lbuf_ram #(
        .AW (AW),
        .PW (PW)
    ) u_ram (
        .clk      (clk),
        .i_a_addr (w_a_addr),
        .i_a_din  (w_a_din),
        .i_a_we   (w_a_we),
        .o_a_dout (w_a_dout),
        .i_b_addr (w_b_addr),
        .i_b_din  ('0),
        .i_b_we   (w_b_we),
        .o_b_dout (w_b_dout)
    );
endmodule

`default_nettype wire

// File: tb/tb_jtkunio_obj_linebuf.sv
// ============================================================================
// tb_jtkunio_obj_linebuf
// Directed plus random bench with a line-level reference model of both banks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_jtkunio_obj_linebuf;
`ifdef JTKUNIO_OBJ_PRIO_EN
    localparam bit         PRIO    = 1'b1;
    localparam int         CPP     = 2;
    localparam logic [5:0] OVL_EXP = 6'h0B;
`else
    localparam bit         PRIO    = 1'b0;
    localparam int         CPP     = 1;
    localparam logic [5:0] OVL_EXP = 6'h16;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pxl_cen = 1'b0;
    logic        LHBL = 1'b1;
    logic [7:0]  hdump = 8'd0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_x = 8'd0;
    logic [2:0]  cmd_pal = 3'd0;
    logic [23:0] cmd_data = 24'd0;
    logic        cmd_hflip = 1'b0;
    logic [5:0]  obj_pxl;

    jtkunio_obj_linebuf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pxl_cen   (pxl_cen),
        .LHBL      (LHBL),
        .hdump     (hdump),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_pal   (cmd_pal),
        .cmd_data  (cmd_data),
        .cmd_hflip (cmd_hflip),
        .obj_pxl   (obj_pxl)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [5:0] mem [2][256];
    int         mb;
    logic [5:0] mhold;
    logic [5:0] cap [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference draw: last-written or first-written wins, no wrap past 255.
    task automatic mdraw(input logic [7:0] x, input logic [2:0] pal,
                         input logic [23:0] data, input bit hf, input int npix);
        for (int p = 0; p < npix; p++) begin
            int         col;
            logic [2:0] idx;
            col = int'(x) + (hf ? 7 - p : p);
            idx = data[3*p +: 3];
            if (col < 256 && idx != 3'd0) begin
                if (!PRIO || mem[mb][col][2:0] == 3'd0) mem[mb][col] = {pal, idx};
            end
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!cmd_ready && n < 64) begin
            tick();
            n++;
        end
    endtask

    task automatic send(input logic [7:0] x, input logic [2:0] pal,
                        input logic [23:0] data, input bit hf);
        int n;
        wait_ready(n);
        check("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_x = x; cmd_pal = pal; cmd_data = data; cmd_hflip = hf;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("busy_after_accept", 32'(cmd_ready), 32'd0);
        mdraw(x, pal, data, hf, 8);
        wait_ready(n);
        check("draw_length", 32'(n), 32'(8 * CPP));
    endtask

    task automatic pulse(input bit chk, input string tag);
        logic [5:0] exp;
        pxl_cen = 1'b1;
        tick();
        pxl_cen = 1'b0;
        exp = LHBL ? mhold : 6'd0;
        if (chk || !LHBL) check(tag, 32'(obj_pxl), 32'(exp));
        mhold = mem[mb ^ 1][hdump];
        mem[mb ^ 1][hdump] = 6'd0;
        repeat (3) tick();
    endtask

    task automatic active(input bit chk);
        LHBL = 1'b1;
        repeat (4) tick();
        for (int h = 0; h <= 256; h++) begin
            hdump = 8'(h);
            pulse(chk, $sformatf("pix_h%0d", h));
            if (h > 0) cap[h-1] = obj_pxl;
        end
    endtask

    task automatic blank(input int npulse, input logic [7:0] h0);
        LHBL = 1'b0;
        mb ^= 1;
        repeat (4) tick();
        for (int i = 0; i < npulse; i++) begin
            hdump = h0 + 8'(i);
            pulse(1'b1, "blank_zero");
        end
    endtask

    function automatic int count_nz();
        int c;
        c = 0;
        for (int i = 0; i < 256; i++) if (cap[i] != 6'd0) c++;
        return c;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < 256; c++) mem[b][c] = 6'd0;
        mb = 0;
        mhold = 6'd0;

        repeat (3) tick();
        check("reset_ready", 32'(cmd_ready), 32'd1);
        check("reset_pxl", 32'(obj_pxl), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Reset arriving mid-draw
        cmd_x = 8'd30; cmd_pal = 3'd2; cmd_data = 24'hFFFFFF; cmd_hflip = 1'b0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (2) tick();
        check("busy_before_reset", 32'(cmd_ready), 32'd0);
        rst_n = 1'b0;
        #2;
        check("async_reset_ready", 32'(cmd_ready), 32'd1);
        check("async_reset_pxl", 32'(obj_pxl), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        mb = 0;
        mhold = 6'd0;

        // Two unchecked lines flush power-up contents of both banks
        active(1'b0);
        blank(2, 8'd200);
        active(1'b0);
        blank(2, 8'd10);

        send(8'd16,  3'd5, 24'hFAC688, 1'b0);
        send(8'd252, 3'd3, 24'hFFFFFF, 1'b1);
        send(8'd40,  3'd1, 24'h6DB6DB, 1'b0);
        send(8'd40,  3'd2, 24'hDB6DB6, 1'b0);
        send(8'd100, 3'd4, 24'h249249, 1'b0);

        active(1'b1);
        check("clear_after_two_swaps", 32'(count_nz()), 32'd0);

        blank(4, 8'd100);
        repeat (6) send(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
                        24'($urandom), 1'($urandom_range(0, 1)));
        active(1'b1);

        check("basic_col16", 32'(cap[16]), 32'h0);
        for (int i = 1; i < 8; i++)
            check($sformatf("basic_col%0d", 16 + i), 32'(cap[16+i]), 32'(6'h28 + 6'(i)));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("flip_col%0d", 252 + i), 32'(cap[252+i]), 32'h1F);
            check($sformatf("nowrap_col%0d", i), 32'(cap[i]), 32'h0);
        end
        for (int i = 0; i < 8; i++)
            check($sformatf("overlap_col%0d", 40 + i), 32'(cap[40+i]), 32'(OVL_EXP));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("blank_erased_col%0d", 100 + i), 32'(cap[100+i]), 32'h0);
            check($sformatf("kept_col%0d", 104 + i), 32'(cap[104+i]), 32'h21);
        end

        for (int l = 0; l < 3; l++) begin
            blank(2, 8'($urandom_range(0, 255)));
            repeat (6) send(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
                            24'($urandom), 1'($urandom_range(0, 1)));
            active(1'b1);
        end

        blank(2, 8'd0);
        active(1'b1);

        // Command accepted 3 clk before the blanking edge
        wait_ready(n);
        cmd_x = 8'd60; cmd_pal = 3'd7; cmd_data = 24'hB6DB6D; cmd_hflip = 1'b0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        check("abort_busy", 32'(cmd_ready), 32'd0);
        mdraw(8'd60, 3'd7, 24'hB6DB6D, 1'b0, 3 / CPP);
        LHBL = 1'b0;
        mb ^= 1;
        tick();
        check("abort_ready", 32'(cmd_ready), 32'd1);
        repeat (3) tick();
        active(1'b1);
        for (int i = 0; i < 8; i++)
            check($sformatf("abort_col%0d", 60 + i), 32'(cap[60+i]),
                  (i < 3 / CPP) ? 32'h3D : 32'h0);

        blank(2, 8'd128);
        active(1'b1);
        blank(3, 8'd61);
        active(1'b1);
        check("erased_line", 32'(count_nz()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
